reg_bank_bus: RTL and testbench
===============================

REG_BANK_BUS -- requirements
Module: reg_bank_bus

Interface
REQ-001 Parameter WIDTH, default 32: data width of every register and the bus.
REQ-002 Parameter NREG, default 16: number of general registers R0..R(NREG-1); legal range 2..64.
REQ-003 Parameter R0_ZERO, default 0: when 1, R0 reads as 0 and writes to R0 are discarded.
REQ-004 Derived localparam SELW = clog2(NREG+4): select width; codes 0..NREG-1 = GPRs, NREG = HI, NREG+1 = LO, NREG+2 = ZLO, NREG+3 = ZHI.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 clr  input  1  reset, asynchronous, active-low.
REQ-007 req_valid  input  1  transfer request valid.
REQ-008 req_ready  output  1  block can accept a request; high only in IDLE.
REQ-009 req_src  input  SELW  source select.
REQ-010 req_dst  input  SELW  destination select.
REQ-011 z_load  input  1  capture z_data into Z this edge.
REQ-012 z_data  input  2*WIDTH  ALU result; [WIDTH-1:0] = ZLO, upper half = ZHI.
REQ-013 bus  output  WIDTH  registered bus value.
REQ-014 bus_valid  output  1  bus holds a valid transfer value.
REQ-015 done  output  1  one-cycle pulse: transfer written.
REQ-016 err  output  1  one-cycle pulse: illegal request rejected.
REQ-017 z_reg  output  2*WIDTH  current Z register contents.

Function
REQ-018 FSM states IDLE, DRIVE, WRITE; handshake accepted on rising edge with req_valid=1 and req_ready=1.
REQ-019 IDLE: legal request -> latch src/dst, go to DRIVE; illegal request -> stay IDLE, err=1 next cycle; no request -> stay IDLE.
REQ-020 Illegal: src >= NREG+4; dst >= NREG+2 (ZLO, ZHI or out of range; Z is written only via z_load).
REQ-021 DRIVE: one cycle; at its closing edge bus <= value of latched src, bus_valid <= 1, go to WRITE.
REQ-022 WRITE: one cycle; done=1, bus_valid=1; at its closing edge dst <= bus, go to IDLE, done and bus_valid clear.
REQ-023 Latency: acceptance edge to dst updated = 2 further edges; throughput 1 transfer per 3 cycles.
REQ-024 bus retains its last value in IDLE; bus_valid=0 in IDLE and DRIVE.
REQ-025 src=dst legal; register value unchanged after the transfer.
REQ-026 R0_ZERO=1: src R0 drives 0; dst R0 completes handshake (done pulses) but R0 stays 0.
REQ-027 z_load takes effect every edge regardless of FSM state; ZLO/ZHI sampled at DRIVE closing edge use pre-edge Z (old value if z_load coincides).
REQ-028 req_src/req_dst changes after acceptance have no effect on the transfer in flight.
REQ-029 done and err never assert in the same cycle.

Reset
REQ-030 clr low asynchronously forces: all GPRs, HI, LO, Z = 0; bus = 0; bus_valid, done, err = 0; state IDLE.
REQ-031 clr low mid-transfer aborts it: no destination write, no done pulse.
REQ-032 req_ready = 1 in IDLE including during reset, but no request is accepted while clr is low; first acceptance possible at first rising edge with clr high.

Verification
REQ-033 Reset, then z_load with z_data=64'h0000_0005_0000_0007 -> z_reg=64'h0000_0005_0000_0007 next cycle; all other registers 0.
REQ-034 Transfer ZLO->R3, then R3->HI -> bus=32'h7 with bus_valid during WRITE; R3=7, then HI=7; done pulses once per transfer; req_ready low for 2 cycles after each acceptance.
REQ-035 R0_ZERO=1: transfer ZHI->R0 then R0->R5 -> done pulses twice, R5=0.
REQ-036 Request with dst=ZLO code (NREG+2=18) -> err=1 for one cycle, no done, no register changes, req_ready stays 1.
REQ-037 z_load of new value 32'hA on the edge that closes DRIVE for ZLO->R1 (old ZLO=7) -> R1=7, z_reg low half=32'hA.
REQ-038 Assert clr low during WRITE of R2->R4 (R2=9) -> R4=0, done never pulses, state IDLE, bus=0 after release.

Source files
------------

// File: rtl/reg_bank_bus.sv
// rtl/reg_bank_bus.sv - register bank with a single shared transfer bus and a 2*WIDTH Z capture register
module reg_bank_bus #(
    parameter int WIDTH   = 32,
    parameter int NREG    = 16,
    parameter bit R0_ZERO = 1'b0,
    localparam int SELW   = $clog2(NREG + 4)
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [SELW-1:0]      req_src,
    input  logic [SELW-1:0]      req_dst,
    input  logic                 z_load,
    input  logic [2*WIDTH-1:0]   z_data,
    output logic [WIDTH-1:0]     bus,
    output logic                 bus_valid,
    output logic                 done,
    output logic                 err,
    output logic [2*WIDTH-1:0]   z_reg
);

    typedef enum logic [1:0] {IDLE, DRIVE, WRITE} state_t;

    state_t            state, state_nx;
    logic [WIDTH-1:0]  gpr [NREG];
    logic [WIDTH-1:0]  hi, lo, rd_val;
    logic [SELW-1:0]   src_q, dst_q;
    logic              accept, legal;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    // Z halves are readable but only writable through z_load
    assign legal     = (32'(req_src) < NREG + 4) && (32'(req_dst) < NREG + 2);
    assign done      = (state == WRITE);
    assign bus_valid = (state == WRITE);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && legal) state_nx = DRIVE;
            DRIVE:   state_nx = WRITE;
            WRITE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NREG; i++) begin
            if (32'(src_q) == i && !(R0_ZERO && i == 0)) rd_val = gpr[i];
        end
        if (32'(src_q) == NREG)     rd_val = hi;
        if (32'(src_q) == NREG + 1) rd_val = lo;
        if (32'(src_q) == NREG + 2) rd_val = z_reg[WIDTH-1:0];
        if (32'(src_q) == NREG + 3) rd_val = z_reg[2*WIDTH-1:WIDTH];
    end

    // Z is sampled pre-edge in DRIVE, so a coinciding z_load is seen only by later reads
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < NREG; i++) gpr[i] <= '0;
            hi    <= '0;
            lo    <= '0;
            z_reg <= '0;
            bus   <= '0;
            src_q <= '0;
            dst_q <= '0;
            err   <= 1'b0;
        end else begin
            err <= accept && !legal;
            if (z_load) z_reg <= z_data;
            if (accept && legal) begin
                src_q <= req_src;
                dst_q <= req_dst;
            end
            if (state == DRIVE) bus <= rd_val;
            if (state == WRITE) begin
                for (int i = 0; i < NREG; i++) begin
                    if (32'(dst_q) == i && !(R0_ZERO && i == 0)) gpr[i] <= bus;
                end
                if (32'(dst_q) == NREG)     hi <= bus;
                if (32'(dst_q) == NREG + 1) lo <= bus;
            end
        end
    end

endmodule

// File: tb/tb_reg_bank_bus.sv
// tb/tb_reg_bank_bus.sv - randomized self-checking bench for reg_bank_bus, with and without R0 hardwired to zero
module tb_reg_bank_bus;

    localparam int W   = 32;
    localparam int N   = 16;
    localparam int HI  = N;
    localparam int LO  = N + 1;
    localparam int ZLO = N + 2;
    localparam int ZHI = N + 3;

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic          req_valid = 1'b0;
    logic          z_load = 1'b0;
    logic [4:0]    req_src = '0;
    logic [4:0]    req_dst = '0;
    logic [63:0]   z_data = '0;
    logic          ready [2];
    logic          bus_valid [2];
    logic          done [2];
    logic          err [2];
    logic [W-1:0]  bus [2];
    logic [63:0]   zr [2];

    // instance 1 has R0 hardwired to zero; both see identical stimulus
    logic [W-1:0]  mreg [2][N+2];
    logic [W-1:0]  mbus [2];
    logic [63:0]   mz;
    int            n_pass = 0;
    int            n_checks = 0;

    always #5 clk = ~clk;

    reg_bank_bus #(.WIDTH(W), .NREG(N), .R0_ZERO(1'b0)) dut0 (
        .clk(clk), .clr(clr), .req_valid(req_valid), .req_ready(ready[0]),
        .req_src(req_src), .req_dst(req_dst), .z_load(z_load), .z_data(z_data),
        .bus(bus[0]), .bus_valid(bus_valid[0]), .done(done[0]), .err(err[0]), .z_reg(zr[0])
    );

    reg_bank_bus #(.WIDTH(W), .NREG(N), .R0_ZERO(1'b1)) dut1 (
        .clk(clk), .clr(clr), .req_valid(req_valid), .req_ready(ready[1]),
        .req_src(req_src), .req_dst(req_dst), .z_load(z_load), .z_data(z_data),
        .bus(bus[1]), .bus_valid(bus_valid[1]), .done(done[1]), .err(err[1]), .z_reg(zr[1])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] mread(input int k, input int s);
        if (s < N)   return (k == 1 && s == 0) ? '0 : mreg[k][s];
        if (s < ZLO) return mreg[k][s];
        if (s == ZLO) return mz[31:0];
        return mz[63:32];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < N + 2; r++) mreg[k][r] = '0;
            mbus[k] = '0;
        end
        mz = '0;
    endtask

    task automatic xfer(input int s, input int d, input bit zl, input logic [63:0] zv);
        logic [W-1:0] e [2];
        for (int k = 0; k < 2; k++) e[k] = mread(k, s);
        req_valid = 1'b1;
        req_src   = 5'(s);
        req_dst   = 5'(d);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("drive_ready", ready[k], 0);
            check("drive_bus_valid", bus_valid[k], 0);
            check("drive_done", done[k], 0);
            check("drive_bus_hold", bus[k], mbus[k]);
        end
        req_src = 5'($urandom);
        req_dst = 5'($urandom);
        z_load  = zl;
        z_data  = zv;
        @(negedge clk);
        if (zl) mz = zv;
        for (int k = 0; k < 2; k++) begin
            check("write_done", done[k], 1);
            check("write_bus_valid", bus_valid[k], 1);
            check("write_bus", bus[k], e[k]);
            check("write_err", err[k], 0);
            check("write_ready", ready[k], 0);
        end
        req_valid = 1'b0;
        z_load    = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!(k == 1 && d == 0)) mreg[k][d] = e[k];
            mbus[k] = e[k];
            check("idle_done", done[k], 0);
            check("idle_ready", ready[k], 1);
            check("idle_bus_hold", bus[k], e[k]);
            check("z_reg", zr[k], mz);
        end
    endtask

    task automatic illegal(input int s, input int d);
        req_valid = 1'b1;
        req_src   = 5'(s);
        req_dst   = 5'(d);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("illegal_err", err[k], 1);
            check("illegal_ready", ready[k], 1);
            check("illegal_done", done[k], 0);
            check("illegal_bus", bus[k], mbus[k]);
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("illegal_err_clear", err[k], 0);
            check("illegal_bus_valid", bus_valid[k], 0);
        end
    endtask

    task automatic zload(input logic [63:0] v);
        z_load = 1'b1;
        z_data = v;
        @(negedge clk);
        z_load = 1'b0;
        mz = v;
        for (int k = 0; k < 2; k++) check("zload", zr[k], mz);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        req_valid = 1'b1;
        req_src   = 5'(ZLO);
        req_dst   = 5'd3;
        @(negedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("reset_ready", ready[k], 1);
            check("reset_bus", bus[k], 0);
            check("reset_bus_valid", bus_valid[k], 0);
            check("reset_done", done[k], 0);
            check("reset_err", err[k], 0);
            check("reset_z", zr[k], 0);
        end
        clr = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) check("post_reset_ready", ready[k], 1);

        zload(64'h0000_0005_0000_0007);
        xfer(ZLO, 3, 1'b0, '0);
        xfer(3, HI, 1'b0, '0);
        xfer(ZHI, 0, 1'b0, '0);
        xfer(0, 5, 1'b0, '0);
        illegal(1, ZLO);
        xfer(ZLO, 1, 1'b1, 64'h0000_0005_0000_000A);

        zload(64'h0000_0000_0000_0009);
        xfer(ZLO, 2, 1'b0, '0);
        req_valid = 1'b1;
        req_src   = 5'd2;
        req_dst   = 5'd4;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) check("abort_in_write", done[k], 1);
        clr = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            check("abort_done", done[k], 0);
            check("abort_bus_valid", bus_valid[k], 0);
            check("abort_bus", bus[k], 0);
            check("abort_ready", ready[k], 1);
        end
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) check("abort_done_after", done[k], 0);
        xfer(4, 4, 1'b0, '0);
        xfer(2, 2, 1'b0, '0);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0, 1: xfer($urandom_range(0, ZHI), $urandom_range(0, LO),
                           1'($urandom_range(0, 1)), {$urandom, $urandom});
                2: begin
                    if ($urandom_range(0, 1) == 1) illegal($urandom_range(ZHI + 1, 31), $urandom_range(0, LO));
                    else illegal($urandom_range(0, 31), $urandom_range(ZLO, 31));
                end
                default: zload({$urandom, $urandom});
            endcase
        end

        for (int r = 0; r <= LO; r++) xfer(r, r, 1'b0, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
